// File: rtl/bmd_axist_rq_egress_fifo.sv
// RQ egress buffer between the BMD requester and the PCIe core s_axis_rq port.
// First-word-fall-through FIFO with optional store-and-forward packet gating.
module bmd_axist_rq_egress_fifo #(
  parameter int C_DATA_WIDTH        = 1024,
  parameter int AXI4_RQ_TUSER_WIDTH = 373,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int DEPTH               = 16,
  parameter int ADDR_W              = $clog2(DEPTH),
  parameter bit STORE_FWD           = 1'b1
) (
  input  logic                           user_clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [C_DATA_WIDTH-1:0]        in_tdata,
  input  logic [AXI4_RQ_TUSER_WIDTH-1:0] in_tuser,
  input  logic [KEEP_WIDTH-1:0]          in_tkeep,
  input  logic                           in_tlast,
  input  logic                           in_tvalid,
  output logic                           in_tready,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic                           s_axis_rq_tlast,
  output logic                           s_axis_rq_tvalid,
  input  logic                           s_axis_rq_tready,
  output logic [ADDR_W:0]                fifo_level,
  output logic [ADDR_W:0]                pkt_count,
  output logic                           oversize_err
);

  localparam int ENTRY_W = 1 + AXI4_RQ_TUSER_WIDTH + KEEP_WIDTH + C_DATA_WIDTH;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rd_entry;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [ADDR_W:0]   pkt_q, pkt_d;
  logic              release_q, release_d;
  logic              oversize_q, oversize_d;
  logic              in_ready_q, in_ready_d;

  logic wr_en;
  logic rd_en;
  logic out_valid;
  logic out_last;
  logic pkt_inc;
  logic pkt_dec;
  logic release_trig;

  assign rd_entry = mem_q[rd_ptr_q];
  assign out_last = rd_entry[ENTRY_W-1];

  assign s_axis_rq_tlast  = out_last;
  assign s_axis_rq_tuser  = rd_entry[ENTRY_W-2 -: AXI4_RQ_TUSER_WIDTH];
  assign s_axis_rq_tkeep  = rd_entry[C_DATA_WIDTH +: KEEP_WIDTH];
  assign s_axis_rq_tdata  = rd_entry[C_DATA_WIDTH-1:0];
  assign s_axis_rq_tvalid = out_valid;

  assign in_tready    = in_ready_q;
  assign fifo_level   = level_q;
  assign pkt_count    = pkt_q;
  assign oversize_err = oversize_q;

  // A full FIFO with no complete packet can never drain in store-and-forward
  // mode, so it falls back to cut-through until that packet's tlast leaves.
  assign release_trig = STORE_FWD && (level_q == FULL_LVL) && (pkt_q == '0);
  assign out_valid    = (level_q != '0) && (!STORE_FWD || (pkt_q != '0) || release_q);

  assign wr_en   = in_tvalid && in_ready_q;
  assign rd_en   = out_valid && s_axis_rq_tready;
  assign pkt_inc = wr_en && in_tlast;
  assign pkt_dec = rd_en && out_last && !(release_q && (pkt_q == '0));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pkt_d      = pkt_q;
    release_d  = release_q;
    oversize_d = oversize_q || release_trig;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    case ({pkt_inc, pkt_dec})
      2'b10:   pkt_d = pkt_q + LVL_ONE;
      2'b01:   pkt_d = pkt_q - LVL_ONE;
      default: pkt_d = pkt_q;
    endcase

    if (release_q) release_d = !(rd_en && out_last);
    else           release_d = release_trig;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      pkt_d      = '0;
      release_d  = 1'b0;
      oversize_d = 1'b0;
    end

    in_ready_d = (level_d < FULL_LVL) && !flush;
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_q      <= '0;
      release_q  <= 1'b0;
      oversize_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_q      <= pkt_d;
      release_q  <= release_d;
      oversize_q <= oversize_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Storage carries no reset; only pointers and counters define what is valid.
  always_ff @(posedge user_clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= {in_tlast, in_tuser, in_tkeep, in_tdata};
  end

endmodule

// File: doc/bmd_axist_rq_egress_fifo.md
Name: bmd_axist_rq_egress_fifo

Overview:
- Store-and-forward / cut-through AXI-ST buffer between the BMD endpoint's requester-request (RQ) output and the PCIe core s_axis_rq input.
- Decouples the BMD write/read request generator from core tready back-pressure.
- In store-and-forward mode, only whole TLPs are presented to the core, so a TLP is never stalled mid-packet by the generator.
- Provides a flush input and occupancy/packet status for the turn-off controller and debug logic.

Parameters:
- C_DATA_WIDTH, 1024, RQ data width in bits.
- AXI4_RQ_TUSER_WIDTH, 373, RQ tuser width.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width (one bit per DWORD).
- DEPTH, 16, FIFO depth in beats; must be a power of two, 4 or more.
- ADDR_W, $clog2(DEPTH), pointer width.
- STORE_FWD, 1, 1 = present a packet only after its tlast beat is stored; 0 = cut-through.

Ports:
- user_clk  in  1  Clock; all logic is on the rising edge.
- reset_n  in  1  Asynchronous active-low reset.
- flush  in  1  Synchronous discard of all FIFO contents.
- in_tdata  in  C_DATA_WIDTH  Upstream data from the BMD endpoint.
- in_tuser  in  AXI4_RQ_TUSER_WIDTH  Upstream tuser.
- in_tkeep  in  KEEP_WIDTH  Upstream tkeep.
- in_tlast  in  1  Upstream end of packet.
- in_tvalid  in  1  Upstream valid.
- in_tready  out  1  Upstream ready.
- s_axis_rq_tdata  out  C_DATA_WIDTH  Data to the core.
- s_axis_rq_tuser  out  AXI4_RQ_TUSER_WIDTH  tuser to the core.
- s_axis_rq_tkeep  out  KEEP_WIDTH  tkeep to the core.
- s_axis_rq_tlast  out  1  End of packet to the core.
- s_axis_rq_tvalid  out  1  Valid to the core.
- s_axis_rq_tready  in  1  Ready from the core.
- fifo_level  out  ADDR_W+1  Number of beats stored.
- pkt_count  out  ADDR_W+1  Number of complete packets stored (tlast beats written and not yet read).
- oversize_err  out  1  Sticky flag: a packet exceeded DEPTH beats in store-and-forward mode.

Behaviour:
- Clock and reset: single clock user_clk; reset_n is asynchronous and active-low.
- Reset values:
  - pointers, fifo_level, pkt_count, oversize_err, s_axis_rq_tvalid and in_tready are all 0.
  - in_tready is registered and rises on the first clock edge after reset_n deasserts.
- Storage:
  - Each entry holds {tlast, tuser, tkeep, tdata}.
  - Write pointer and read pointer are ADDR_W bits wide and wrap modulo DEPTH.
  - Output is first-word-fall-through: s_axis_rq_* data fields equal mem[rd_ptr] combinationally.
- Write and read conditions:
  - Write occurs on in_tvalid && in_tready.
  - Read occurs on s_axis_rq_tvalid && s_axis_rq_tready.
- Ready:
  - in_tready <= (fifo_level_next < DEPTH) && !flush.
  - A write is never accepted into a full FIFO, even when a read happens in the same cycle (no pass-through).
- Valid and latency:
  - STORE_FWD=0: s_axis_rq_tvalid = (fifo_level != 0). A beat written in cycle N is visible in cycle N+1.
  - STORE_FWD=1: s_axis_rq_tvalid = (fifo_level != 0) && (pkt_count != 0 || release). A tlast beat written in cycle N makes its packet visible in cycle N+1.
- Oversize release (STORE_FWD=1 only):
  - When fifo_level == DEPTH and pkt_count == 0, set release=1 and set oversize_err=1.
  - release forces cut-through until the next tlast beat is read, then clears.
- pkt_count:
  - +1 on a write with tlast; -1 on a read with tlast; unchanged when both occur in the same cycle.
  - A tlast read while release=1 with pkt_count == 0 does not decrement.
- fifo_level: +1 on write only, -1 on read only, unchanged when both occur.
- AXI stability: while s_axis_rq_tvalid && !s_axis_rq_tready, the output data fields are held stable and tvalid does not drop.
- Flush:
  - The next edge clears pointers, fifo_level, pkt_count, release and oversize_err.
  - in_tready is 0 in the cycle following flush.
  - s_axis_rq_tvalid is 0 from that edge on.
  - Flush mid-packet discards the partial packet on both sides. The user must flush only when the core is idle or in link-down.
- Reset asserted mid-operation: contents are discarded and all outputs go to their reset values asynchronously.
- Errors: there is no overflow or underflow path; both are prevented by the ready/valid gating above.

Test Plan:
- Cut-through: STORE_FWD=0, 1-beat packet written at cycle 10, tready=1 -> s_axis_rq_tvalid=1 at cycle 11 with identical data/keep/user/last; fifo_level returns to 0 at cycle 12.
- Store-and-forward: STORE_FWD=1, 3-beat packet written on cycles 10-12 (tlast at 12) -> tvalid stays 0 through cycle 12, rises at 13; pkt_count=1 at 13, back to 0 after the tlast read.
- Full/back-pressure: tready=0, write 16 beats -> in_tready=0 once fifo_level=16; then tready=1 for one cycle -> fifo_level=15 and in_tready=1 the next cycle. All 16 beats emerge in order; data held stable while stalled.
- Oversize: STORE_FWD=1, 20-beat packet with DEPTH=16 -> oversize_err=1 when level reaches 16 with pkt_count=0; all 20 beats delivered in order; release clears after tlast.
- Simultaneous tlast write and tlast read: two 1-beat packets streaming with tready=1 -> pkt_count stays 1; no bubble on s_axis_rq_tvalid.
- Flush and reset mid-packet: 5 beats stored, then flush=1 -> level=0, pkt_count=0, tvalid=0 next cycle. Repeat with reset_n pulsed low mid-cycle -> outputs clear immediately without waiting for a clock edge.
